// File: rtl/rx_fcs_sequencer.sv
// rtl/rx_fcs_sequencer.sv - RX frame sequencer for the CRC-32 engine: FCS strip and per-frame status
// Optional per-frame statistics counters are enabled by defining RX_FCS_STATS_EN.
module rx_fcs_sequencer #(
  parameter logic [31:0] CRC_RESIDUE     = 32'hC704DD7B,
  parameter int          MIN_FRAME_BYTES = 64,
  parameter int          MAX_FRAME_BYTES = 1518,
  parameter int          LEN_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_err,
  output logic             crc_en,
  output logic             crc_init,
  output logic [7:0]       crc_data,
  input  logic [31:0]      crc_value,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             fcs_err,
  output logic             runt_err,
  output logic             oversize_err,
  output logic             phy_err,
  output logic [LEN_W-1:0] frame_len
`ifdef RX_FCS_STATS_EN
  ,
  output logic [31:0]      stat_good_frames,
  output logic [31:0]      stat_fcs_err_frames,
  output logic [31:0]      stat_runt_frames
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  state_t           state;
  logic [7:0]       dl [4];
  logic [2:0]       fill;
  logic [7:0]       hold;
  logic             hold_v;
  logic [LEN_W-1:0] count;
  logic             phy_sticky;

  logic start;
  logic shift_out;
  logic is_check;

  // Any byte seen outside ACTIVE is byte 0 of a new frame, including one arriving in CHECK.
  assign start     = in_valid && (state != ACTIVE);
  assign shift_out = in_valid && (state == ACTIVE) && (fill == 3'd4);
  assign is_check  = (state == CHECK);

  always_comb begin
    crc_en       = in_valid;
    crc_data     = in_data;
    crc_init     = start;
    out_valid    = hold_v && (is_check || shift_out);
    out_data     = out_valid ? hold : 8'h00;
    out_last     = is_check && hold_v;
    frame_done   = is_check;
    fcs_err      = is_check && (crc_value != CRC_RESIDUE);
    runt_err     = is_check && (count < MIN_LEN);
    oversize_err = is_check && (count > MAX_LEN);
    phy_err      = is_check && phy_sticky;
    frame_ok     = is_check && !(fcs_err || runt_err || oversize_err || phy_err);
    frame_len    = is_check ? count : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fill       <= 3'd0;
      hold       <= 8'h00;
      hold_v     <= 1'b0;
      count      <= '0;
      phy_sticky <= 1'b0;
      for (int i = 0; i < 4; i++) dl[i] <= 8'h00;
    end else begin
      case (state)
        IDLE, CHECK: begin
          if (in_valid) begin
            dl[0]      <= in_data;
            fill       <= 3'd1;
            hold_v     <= 1'b0;
            count      <= LEN_W'(1);
            phy_sticky <= in_err;
            state      <= in_last ? CHECK : ACTIVE;
          end else begin
            fill       <= 3'd0;
            hold_v     <= 1'b0;
            count      <= '0;
            phy_sticky <= 1'b0;
            state      <= IDLE;
          end
        end
        ACTIVE: begin
          if (in_valid) begin
            dl[3] <= dl[2];
            dl[2] <= dl[1];
            dl[1] <= dl[0];
            dl[0] <= in_data;
            // Once full, the oldest byte is certainly payload and moves to the hold register.
            if (fill == 3'd4) begin
              hold   <= dl[3];
              hold_v <= 1'b1;
            end else begin
              fill <= fill + 3'd1;
            end
            count      <= (count == '1) ? count : count + 1'b1;
            phy_sticky <= phy_sticky | in_err;
            if (in_last) state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_FCS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_frames    <= 32'd0;
      stat_fcs_err_frames <= 32'd0;
      stat_runt_frames    <= 32'd0;
    end else begin
      if (frame_ok && stat_good_frames != '1)    stat_good_frames    <= stat_good_frames + 32'd1;
      if (fcs_err && stat_fcs_err_frames != '1)  stat_fcs_err_frames <= stat_fcs_err_frames + 32'd1;
      if (runt_err && stat_runt_frames != '1)    stat_runt_frames    <= stat_runt_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_fcs_sequencer.sv
// tb/tb_rx_fcs_sequencer.sv - scoreboard bench for rx_fcs_sequencer with a behavioural CRC-32 engine
module tb_rx_fcs_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_err = 1'b0;
  logic        crc_en, crc_init;
  logic [7:0]  crc_data;
  logic [31:0] crc_value = 32'h0;
  logic        out_valid, out_last;
  logic [7:0]  out_data;
  logic        frame_done, frame_ok, fcs_err, runt_err, oversize_err, phy_err;
  logic [15:0] frame_len;
`ifdef RX_FCS_STATS_EN
  logic [31:0] stat_good_frames, stat_fcs_err_frames, stat_runt_frames;
`endif

  rx_fcs_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .crc_en(crc_en), .crc_init(crc_init), .crc_data(crc_data), .crc_value(crc_value),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done), .frame_ok(frame_ok), .fcs_err(fcs_err), .runt_err(runt_err),
    .oversize_err(oversize_err), .phy_err(phy_err), .frame_len(frame_len)
`ifdef RX_FCS_STATS_EN
    ,
    .stat_good_frames(stat_good_frames), .stat_fcs_err_frames(stat_fcs_err_frames),
    .stat_runt_frames(stat_runt_frames)
`endif
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        fcs;
    logic        runt;
    logic        over;
    logic        phy;
    logic [15:0] len;
  } status_t;

  logic [8:0] pay_q [$];
  status_t    stat_q [$];
  logic       init_q [$];
  logic [7:0] fr [0:1599];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 7; b >= 0; b--) begin
      fb = c[31] ^ d[b];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  // Engine register follows crc_en by one clock.
  always_ff @(posedge clk)
    if (crc_en) crc_value <= crc_byte(crc_init ? 32'hFFFFFFFF : crc_value, crc_data);

  task automatic build_frame(input int plen, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      fr[i] = 8'(seed + i * 13);
      c = crc_byte(c, fr[i]);
    end
    c = ~c;
    fr[plen]   = c[31:24];
    fr[plen+1] = c[23:16];
    fr[plen+2] = c[15:8];
    fr[plen+3] = c[7:0];
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic e);
    in_valid = v; in_data = d; in_last = l; in_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int n, input int err_idx, input bit gaps, input int abort_at,
                            input status_t exp);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      init_q.push_back(i == 0);
      if (i >= 5) pay_q.push_back({1'b0, fr[i-5]});
      if (i == n - 1) begin
        if (n >= 5) pay_q.push_back({1'b1, fr[n-5]});
        stat_q.push_back(exp);
      end
      cycle(1'b1, fr[i], i == n - 1, i == err_idx);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents something.
  always @(negedge clk) begin
    if (!rst) begin
      if (crc_en) begin
        checks++;
        if (init_q.size() == 0) begin
          failures++; $display("FAIL crc_init_unexpected_byte got=%0b required=none", crc_init);
        end else begin
          logic e_init;
          e_init = init_q.pop_front();
          if (crc_init !== e_init) begin
            failures++; $display("FAIL crc_init got=%0b required=%0b", crc_init, e_init);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (pay_q.size() == 0) begin
          failures++; $display("FAIL payload_unexpected got=%02h last=%0b required=none", out_data, out_last);
        end else begin
          logic [8:0] e_pay;
          e_pay = pay_q.pop_front();
          if ({out_last, out_data} !== e_pay) begin
            failures++;
            $display("FAIL payload got last=%0b data=%02h required last=%0b data=%02h",
                     out_last, out_data, e_pay[8], e_pay[7:0]);
          end
        end
      end
      checks++;
      if (frame_done) begin
        if (stat_q.size() == 0) begin
          failures++; $display("FAIL status_unexpected_frame_done len=%0d required=none", frame_len);
        end else begin
          status_t e_st;
          status_t got;
          e_st = stat_q.pop_front();
          got  = {frame_ok, fcs_err, runt_err, oversize_err, phy_err, frame_len};
          if (got !== e_st) begin
            failures++;
            $display("FAIL status got ok=%0b fcs=%0b runt=%0b over=%0b phy=%0b len=%0d required ok=%0b fcs=%0b runt=%0b over=%0b phy=%0b len=%0d",
                     got.ok, got.fcs, got.runt, got.over, got.phy, got.len,
                     e_st.ok, e_st.fcs, e_st.runt, e_st.over, e_st.phy, e_st.len);
          end
        end
      end else if ({frame_ok, fcs_err, runt_err, oversize_err, phy_err, frame_len} !== '0) begin
        failures++;
        $display("FAIL status_idle got ok=%0b fcs=%0b runt=%0b over=%0b phy=%0b len=%0d required all 0",
                 frame_ok, fcs_err, runt_err, oversize_err, phy_err, frame_len);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    checks++;
    if ({crc_en, crc_init, out_valid, out_data, out_last, frame_done, frame_ok, fcs_err,
         runt_err, oversize_err, phy_err, frame_len} !== '0) begin
      failures++; $display("FAIL reset_outputs got nonzero output required all 0");
    end
    @(posedge clk); #1;

    // Good 64-byte frame.
    build_frame(60, 1);
    send_frame(64, -1, 1'b0, -1, '{ok:1, fcs:0, runt:0, over:0, phy:0, len:16'd64});
    idle(3);

    // Payload byte 10 corrupted after FCS was computed.
    build_frame(60, 1);
    fr[10] = fr[10] ^ 8'h01;
    send_frame(64, -1, 1'b0, -1, '{ok:0, fcs:1, runt:0, over:0, phy:0, len:16'd64});
    idle(3);

    // 10-byte runt with valid FCS.
    build_frame(6, 7);
    send_frame(10, -1, 1'b0, -1, '{ok:0, fcs:0, runt:1, over:0, phy:0, len:16'd10});
    idle(2);

    // 3-byte fragment: no payload at all.
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
    send_frame(3, -1, 1'b0, -1, '{ok:0, fcs:1, runt:1, over:0, phy:0, len:16'd3});
    idle(2);

    // 5-byte frame: exactly one payload byte, emitted with frame_done.
    build_frame(1, 9);
    send_frame(5, -1, 1'b0, -1, '{ok:0, fcs:0, runt:1, over:0, phy:0, len:16'd5});
    idle(2);

    // 1519-byte oversize frame with good FCS.
    build_frame(1515, 3);
    send_frame(1519, -1, 1'b0, -1, '{ok:0, fcs:0, runt:0, over:1, phy:0, len:16'd1519});
    idle(3);

    // PHY error on byte 30.
    build_frame(60, 5);
    send_frame(64, 30, 1'b0, -1, '{ok:0, fcs:0, runt:0, over:0, phy:1, len:16'd64});
    idle(3);

    // Back-to-back good frames, second byte 0 lands in CHECK, with random gaps.
    build_frame(60, 21);
    send_frame(64, -1, 1'b1, -1, '{ok:1, fcs:0, runt:0, over:0, phy:0, len:16'd64});
    build_frame(60, 77);
    send_frame(64, -1, 1'b1, -1, '{ok:1, fcs:0, runt:0, over:0, phy:0, len:16'd64});
    idle(3);

    // Reset at byte 20 discards the frame, then a good frame.
    build_frame(60, 40);
    send_frame(64, -1, 1'b0, 20, '{ok:1, fcs:0, runt:0, over:0, phy:0, len:16'd64});
    do_reset();
    build_frame(60, 41);
    send_frame(64, -1, 1'b0, -1, '{ok:1, fcs:0, runt:0, over:0, phy:0, len:16'd64});
    idle(5);

    checks++;
    if (pay_q.size() != 0) begin
      failures++; $display("FAIL payload_drain got_left=%0d required=0", pay_q.size());
    end
    checks++;
    if (stat_q.size() != 0) begin
      failures++; $display("FAIL status_drain got_left=%0d required=0", stat_q.size());
    end
    checks++;
    if (init_q.size() != 0) begin
      failures++; $display("FAIL init_drain got_left=%0d required=0", init_q.size());
    end
`ifdef RX_FCS_STATS_EN
    checks++;
    if ({stat_good_frames, stat_fcs_err_frames, stat_runt_frames} !== {32'd1, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL stats got good=%0d fcs=%0d runt=%0d required good=1 fcs=0 runt=0",
               stat_good_frames, stat_fcs_err_frames, stat_runt_frames);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
